// File: rtl/instr_stream_loader.sv
// instr_stream_loader: run-time loader for the mips16_sc instruction store.
// Accepts a byte stream (valid/ready), reads a 16-bit big-endian word count N,
// then assembles N big-endian 32-bit words and writes them to consecutive
// instruction addresses starting at 0 while holding the core stalled.
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes; a mismatch parks the loader in ERROR.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start                   pulse; begins a load from IDLE/DONE(/ERROR)
//   rx_data/rx_valid/rx_ready  byte stream handshake (rx_ready registered)
//   instr_wr_en/addr/data   one-cycle write strobe to instruction store
//   instr_stall_sl          high while a load is in progress
//   ready_out               program loaded
//   words_loaded            words written this load (saturates at DEPTH)
//   overflow                header count exceeded DEPTH
//   err                     checksum mismatch (0 when feature disabled)
module instr_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  instr_wr_en,
    output logic [ADDR_WIDTH-1:0] instr_wr_addr,
    output logic [31:0]           instr_wr_data,
    output logic                  instr_stall_sl,
    output logic                  ready_out,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  overflow,
    output logic                  err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned HDR_W = CNT_W + 1;
    localparam int unsigned WL_W  = ADDR_WIDTH + 1;
    localparam logic [WL_W-1:0]  DEPTH_WL = WL_W'(DEPTH);
    localparam logic [HDR_W-1:0] DEPTH_N  = HDR_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_FIN, S_DONE, S_CSUM, S_ERROR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   word_cnt_n;   // header word count N
    logic [CNT_W-1:0]   word_idx;     // index of the word being assembled
    logic [1:0]         byte_cnt;
    logic [23:0]        word_buf;     // first three bytes of the current word
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    logic               accept;
    logic               can_start;
    logic               last_word;
    logic               in_range;
    logic [CNT_W-1:0]   hdr_n;

    // Handshake and decode helpers
    always_comb begin
        accept    = rx_valid && rx_ready;
        hdr_n     = {word_cnt_n[15:8], rx_data};
        last_word = (word_idx + 16'd1) == word_cnt_n;
        in_range  = HDR_W'(word_idx) < DEPTH_N;
        can_start = (state == S_IDLE) || (state == S_DONE);
`ifdef LOADER_CHECKSUM_EN
        can_start = can_start || (state == S_ERROR);
`endif
    end

`ifndef LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif

    // Loader FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            rx_ready       <= 1'b0;
            instr_wr_en    <= 1'b0;
            instr_wr_addr  <= '0;
            instr_wr_data  <= '0;
            instr_stall_sl <= 1'b0;
            ready_out      <= 1'b0;
            words_loaded   <= '0;
            overflow       <= 1'b0;
            word_cnt_n     <= '0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            word_buf       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= '0;
            err            <= 1'b0;
`endif
        end else begin
            instr_wr_en <= 1'b0;
            if (start && can_start) begin
                state          <= S_LEN_HI;
                rx_ready       <= 1'b1;
                instr_stall_sl <= 1'b1;
                ready_out      <= 1'b0;
                words_loaded   <= '0;
                overflow       <= 1'b0;
                word_cnt_n     <= '0;
                word_idx       <= '0;
                byte_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum           <= '0;
                err            <= 1'b0;
`endif
            end else begin
                case (state)
                    S_LEN_HI: begin
                        if (accept) begin
                            word_cnt_n[15:8] <= rx_data;
                            state            <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (accept) begin
                            word_cnt_n[7:0] <= rx_data;
                            overflow        <= HDR_W'(hdr_n) > DEPTH_N;
                            if (hdr_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                state    <= S_CSUM;
`else
                                state    <= S_FIN;
                                rx_ready <= 1'b0;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            csum     <= csum ^ rx_data;
`endif
                            if (byte_cnt != 2'd3) begin
                                word_buf <= {word_buf[15:0], rx_data};
                            end else begin
                                // Out-of-range words are consumed but not written
                                instr_wr_en   <= in_range;
                                instr_wr_addr <= ADDR_WIDTH'(word_idx);
                                instr_wr_data <= {word_buf, rx_data};
                                word_idx      <= word_idx + 16'd1;
                                if (words_loaded < DEPTH_WL)
                                    words_loaded <= words_loaded + WL_W'(1);
                                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                    state    <= S_CSUM;
`else
                                    state    <= S_FIN;
                                    rx_ready <= 1'b0;
`endif
                                end
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (accept) begin
                            rx_ready <= 1'b0;
                            if (rx_data == csum) begin
                                state <= S_FIN;
                            end else begin
                                state <= S_ERROR;
                                err   <= 1'b1;
                            end
                        end
                    end
`endif
                    // Lets the final write retire before signalling ready
                    S_FIN: begin
                        state          <= S_DONE;
                        ready_out      <= 1'b1;
                        instr_stall_sl <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Self-checking bench for instr_stream_loader (DEPTH=4 to reach overflow).
module tb_instr_stream_loader;

    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          instr_wr_en;
    logic [AW-1:0] instr_wr_addr;
    logic [31:0]   instr_wr_data;
    logic          instr_stall_sl;
    logic          ready_out;
    logic [AW:0]   words_loaded;
    logic          overflow;
    logic          err;

    instr_stream_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr),
        .instr_wr_data(instr_wr_data), .instr_stall_sl(instr_stall_sl),
        .ready_out(ready_out), .words_loaded(words_loaded),
        .overflow(overflow), .err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    wr_t wr_q[$];
    int   ready_rise = -1;
    logic ready_d = 1'b0;

    // Observe writes and the ready rising edge away from the active edge
    always @(negedge clock) begin
        if (instr_wr_en) wr_q.push_back('{instr_wr_addr, instr_wr_data});
        if (ready_out && !ready_d && ready_rise < 0) ready_rise = cyc;
        ready_d = ready_out;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    // Push bytes through the handshake; mode 0 always valid, 1 alternating, 2 random
    task automatic send_bytes(input logic [7:0] b[$], input int mode, output int hs);
        int i = 0;
        int guard = 0;
        bit v;
        hs = -1;
        while (i < b.size() && guard < 4000) begin
            @(negedge clock);
            guard++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 1;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            rx_valid = v;
            rx_data  = v ? b[i] : 8'($urandom);
            if (v && rx_ready) begin
                i++;
                hs = cyc + 1;
            end
        end
        @(negedge clock);
        rx_valid = 1'b0;
        if (i != b.size()) chk("handshake_timeout", 64'(i), 64'(b.size()));
    endtask

    // Full frame: words 0/1 fixed, the rest random; expectations from the frame itself
    task automatic run_frame(input string name, input int n, input int mode, input bit bad,
                             input int exp_wl, input bit exp_ovf);
        logic [7:0]  b[$];
        logic [31:0] w[$];
        logic [7:0]  x;
        logic [7:0]  by;
        int hs;
        int nw;
        x = 8'h00;
        for (int k = 0; k < n; k++)
            w.push_back(k == 0 ? 32'h20010005 : k == 1 ? 32'hAC010064 : 32'($urandom));
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        foreach (w[k]) begin
            for (int j = 3; j >= 0; j--) begin
                by = w[k][8*j +: 8];
                b.push_back(by);
                x ^= by;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        b.push_back(bad ? ~x : x);
`endif
        wr_q.delete();
        ready_rise = -1;
        pulse_start();
        chk({name, "_stall_busy"}, 64'(instr_stall_sl), 64'(1));
        send_bytes(b, mode, hs);
        repeat (4) @(negedge clock);
        nw = (n < int'(DEPTH)) ? n : int'(DEPTH);
        chk({name, "_nwrites"}, 64'(wr_q.size()), 64'(nw));
        for (int k = 0; k < nw && k < wr_q.size(); k++) begin
            chk($sformatf("%s_addr%0d", name, k), 64'(wr_q[k].addr), 64'(k));
            chk($sformatf("%s_data%0d", name, k), 64'(wr_q[k].data), 64'(w[k]));
        end
        chk({name, "_words_loaded"}, 64'(words_loaded), 64'(exp_wl));
        chk({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        if (bad) begin
            chk({name, "_err"}, 64'(err), 64'(1));
            chk({name, "_ready"}, 64'(ready_out), 64'(0));
            chk({name, "_stall"}, 64'(instr_stall_sl), 64'(1));
            chk({name, "_rise"}, 64'(ready_rise), 64'(-1));
        end else begin
            chk({name, "_err"}, 64'(err), 64'(0));
            chk({name, "_ready"}, 64'(ready_out), 64'(1));
            chk({name, "_stall"}, 64'(instr_stall_sl), 64'(0));
            chk({name, "_rise"}, 64'(ready_rise), 64'(hs + 1));
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rx_ready"}, 64'(rx_ready), 64'(0));
        chk({name, "_wr_en"}, 64'(instr_wr_en), 64'(0));
        chk({name, "_wr_addr"}, 64'(instr_wr_addr), 64'(0));
        chk({name, "_wr_data"}, 64'(instr_wr_data), 64'(0));
        chk({name, "_stall"}, 64'(instr_stall_sl), 64'(0));
        chk({name, "_ready"}, 64'(ready_out), 64'(0));
        chk({name, "_wl"}, 64'(words_loaded), 64'(0));
        chk({name, "_ovf"}, 64'(overflow), 64'(0));
        chk({name, "_err"}, 64'(err), 64'(0));
    endtask

    typedef struct { int n; int mode; bit bad; int exp_wl; bit exp_ovf; } vec_t;
    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pb[$];
        int hs;
        int n;
        int md;

        tbl[0] = '{2, 0, 1'b0, 2, 1'b0};   // basic two-word load
        tbl[1] = '{2, 1, 1'b0, 2, 1'b0};   // same frame, back-pressure
        tbl[2] = '{0, 0, 1'b0, 0, 1'b0};   // empty program
        tbl[3] = '{6, 0, 1'b0, 4, 1'b1};   // overflow, 24 data bytes
        tbl[4] = '{4, 2, 1'b0, 4, 1'b0};   // exactly DEPTH
        tbl[5] = '{5, 2, 1'b0, 4, 1'b1};   // DEPTH+1
        tbl[6] = '{1, 0, 1'b0, 1, 1'b0};
        tbl[7] = '{3, 1, 1'b0, 3, 1'b0};

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;

        foreach (tbl[i])
            run_frame($sformatf("vec%0d", i), tbl[i].n, tbl[i].mode, tbl[i].bad,
                      tbl[i].exp_wl, tbl[i].exp_ovf);

        // Reset in DATA after 5 bytes, then a clean one-word load
        pulse_start();
        pb = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        send_bytes(pb, 0, hs);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("midload_reset");
        reset = 1'b0;
        run_frame("after_reset", 1, 0, 1'b0, 1, 1'b0);

        // N==0 with a start pulse inside LEN_LO that must be ignored
        wr_q.delete();
        ready_rise = -1;
        pulse_start();
        pb = '{8'h00};
        send_bytes(pb, 0, hs);
        pulse_start();
`ifdef LOADER_CHECKSUM_EN
        pb = '{8'h00, 8'h00};
`else
        pb = '{8'h00};
`endif
        send_bytes(pb, 0, hs);
        repeat (4) @(negedge clock);
        chk("n0_nwrites", 64'(wr_q.size()), 64'(0));
        chk("n0_ready", 64'(ready_out), 64'(1));
        chk("n0_rise", 64'(ready_rise), 64'(hs + 1));
        chk("n0_wl", 64'(words_loaded), 64'(0));

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad on 12 34 56 78 (XOR 0x08)
        pulse_start();
        pb = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_bytes(pb, 0, hs);
        repeat (3) @(negedge clock);
        chk("csum_ok_ready", 64'(ready_out), 64'(1));
        chk("csum_ok_err", 64'(err), 64'(0));
        pulse_start();
        pb = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
        send_bytes(pb, 0, hs);
        repeat (3) @(negedge clock);
        chk("csum_bad_err", 64'(err), 64'(1));
        chk("csum_bad_ready", 64'(ready_out), 64'(0));
        chk("csum_bad_stall", 64'(instr_stall_sl), 64'(1));
        pulse_start();
        chk("csum_restart_err", 64'(err), 64'(0));
        run_frame("csum_bad_frame", 2, 0, 1'b1, 2, 1'b0);
        run_frame("csum_recover", 3, 2, 1'b0, 3, 1'b0);
`endif

        // Random frames checked against the frame-level model
        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(0, 9));
            md = int'($urandom_range(0, 2));
            run_frame($sformatf("rand%0d", r), n, md, 1'b0,
                      (n < int'(DEPTH)) ? n : int'(DEPTH), n > int'(DEPTH));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
